// File: rtl/line_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// line_prefetch_buffer
//
// Scanline prefetch stage in front of the 5-bit color mapper. While line y is
// on screen, the indices for line y+1 are fetched from frame memory into one
// half of a ping-pong line buffer. The other half is played back one index
// per pixel clock.
//
// Ports
//   Clk            in   pixel clock
//   Reset          in   asynchronous reset, active low
//   line_start     in   one-cycle pulse at DrawX == 0 of every line
//   DrawX, DrawY   in   current pixel column / line
//   frame_base     in   word address of line 0, sampled at line_start
//   mem_req        out  fetch request, address held until mem_ack
//   mem_addr       out  word address of the request
//   mem_ack        in   mem_data valid for the current mem_addr
//   mem_data       in   four 5-bit indices, bits [4:0] = leftmost pixel
//   clr_underrun   in   clears the sticky underrun flag
//   memMappedValue out  palette index, one cycle after DrawX/DrawY
//   underrun       out  sticky: a line fetch was cut short by line_start
// ---------------------------------------------------------------------------
module line_prefetch_buffer #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int V_TOTAL        = 525,
  parameter int WORDS_PER_LINE = 160,
  parameter int ADDR_W         = 17
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              line_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [19:0]       mem_data,
  input  logic              clr_underrun,
  output logic [4:0]        memMappedValue,
  output logic              underrun
);

  localparam int                WIDX_W    = $clog2(WORDS_PER_LINE);
  localparam logic [9:0]        LAST_LINE = 10'(V_TOTAL - 1);
  localparam logic [9:0]        V_LIMIT   = 10'(V_ACTIVE);
  localparam logic [9:0]        H_LIMIT   = 10'(H_ACTIVE);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_LINE - 1);
  localparam logic [WIDX_W-1:0] IDX_ONE   = WIDX_W'(1);
  localparam logic [WIDX_W-1:0] IDX_ZERO  = WIDX_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [WIDX_W-1:0]   word_idx_q;
  logic                bank_q;      // bank of the line being fetched (t[0])
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                underrun_q;
  logic [4:0]          pix_q;

  // Line storage is deliberately not reset.
  logic [19:0]         bank0_q [WORDS_PER_LINE];
  logic [19:0]         bank1_q [WORDS_PER_LINE];

  logic [9:0]          tgt_d;
  logic                tgt_ok_d;
  logic [ADDR_W-1:0]   tgt_ext_d;
  logic [ADDR_W-1:0]   start_addr_d;
  logic                wr_en_d;
  logic                blank_d;
  logic [WIDX_W-1:0]   rd_idx_d;
  logic [19:0]         rd_word_d;
  logic [4:0]          pix_d;
  logic                underrun_d;

  // Target line, its first word address, write enable and playback select.
  always_comb begin
    tgt_d        = 10'd0;
    tgt_ok_d     = 1'b0;
    tgt_ext_d    = ADDR_ZERO;
    start_addr_d = ADDR_ZERO;
    wr_en_d      = 1'b0;
    blank_d      = 1'b0;
    rd_idx_d     = IDX_ZERO;
    rd_word_d    = 20'd0;
    pix_d        = 5'd0;
    underrun_d   = underrun_q;

    if (DrawY == LAST_LINE) begin
      tgt_d = 10'd0;
    end else begin
      tgt_d = DrawY + 10'd1;
    end
    tgt_ok_d  = (tgt_d < V_LIMIT);
    tgt_ext_d = ADDR_W'(tgt_d);
    // t*160 as (t<<7)+(t<<5); the sum wraps modulo 2^ADDR_W.
    start_addr_d = frame_base + (tgt_ext_d << 3'd7) + (tgt_ext_d << 3'd5);

    // An ack coinciding with line_start belongs to the abandoned line.
    wr_en_d = (state_q == ST_FETCH) && mem_ack && !line_start;

    blank_d  = (DrawX >= H_LIMIT) || (DrawY >= V_LIMIT);
    rd_idx_d = WIDX_W'(DrawX[9:2]);
    if (DrawY[0]) begin
      rd_word_d = bank1_q[rd_idx_d];
    end else begin
      rd_word_d = bank0_q[rd_idx_d];
    end
    case (DrawX[1:0])
      2'd0:    pix_d = rd_word_d[4:0];
      2'd1:    pix_d = rd_word_d[9:5];
      2'd2:    pix_d = rd_word_d[14:10];
      2'd3:    pix_d = rd_word_d[19:15];
      default: pix_d = 5'd0;
    endcase

    // Setting wins over clearing in the same cycle.
    if (line_start && (state_q == ST_FETCH)) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Fetch FSM with registered request, address and underrun flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= IDX_ZERO;
      bank_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= ADDR_ZERO;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      case (state_q)
        ST_FETCH: begin
          if (line_start) begin
            // Partial line is dropped; restart for the new target if any.
            if (tgt_ok_d) begin
              word_idx_q <= IDX_ZERO;
              bank_q     <= tgt_d[0];
              mem_addr_q <= start_addr_d;
              mem_req_q  <= 1'b1;
            end else begin
              state_q   <= ST_IDLE;
              mem_req_q <= 1'b0;
            end
          end else if (mem_ack) begin
            word_idx_q <= word_idx_q + IDX_ONE;
            if (word_idx_q == LAST_WORD) begin
              state_q   <= ST_DONE;
              mem_req_q <= 1'b0;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_ONE;
            end
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (line_start && tgt_ok_d) begin
            state_q    <= ST_FETCH;
            word_idx_q <= IDX_ZERO;
            bank_q     <= tgt_d[0];
            mem_addr_q <= start_addr_d;
            mem_req_q  <= 1'b1;
          end else begin
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer write port.
  always_ff @(posedge Clk) begin
    if (wr_en_d) begin
      if (bank_q) begin
        bank1_q[word_idx_q] <= mem_data;
      end else begin
        bank0_q[word_idx_q] <= mem_data;
      end
    end
  end

  // Playback register: one cycle behind DrawX/DrawY, zero in blanking.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pix_q <= 5'd0;
    end else if (blank_d) begin
      pix_q <= 5'd0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign underrun       = underrun_q;
  assign memMappedValue = pix_q;

endmodule

// File: tb/tb_line_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// Bench for line_prefetch_buffer. The bench plays the frame memory, drives
// whole lines of DrawX/DrawY, and predicts every output from a line-level
// model: an active fetch (line, base, word), two line banks and the flag.
// ---------------------------------------------------------------------------
module tb_line_prefetch_buffer;

  localparam int ACK_HIGH = 0;
  localparam int ACK_RAND = 1;
  localparam int ACK_LOW  = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        line_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [16:0] frame_base;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_ack;
  logic [19:0] mem_data;
  logic        clr_underrun;
  logic [4:0]  memMappedValue;
  logic        underrun;

  int vectors    = 0;
  int miscompares = 0;

  // reference model
  bit          fetching;
  int          m_t;
  int          m_base;
  int          m_idx;
  bit          exp_underrun;
  logic [4:0]  exp_pix;
  bit          pix_known;
  logic [19:0] refbank  [2][160];
  bit          refvalid [2][160];

  line_prefetch_buffer dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .line_start     (line_start),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .frame_base     (frame_base),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .clr_underrun   (clr_underrun),
    .memMappedValue (memMappedValue),
    .underrun       (underrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [19:0] memword(int a);
    logic [31:0] x;
    x = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
    return x[19:0] ^ x[31:12];
  endfunction

  function automatic int model_addr();
    return (m_base + m_t * 160 + m_idx) % 131072;
  endfunction

  task automatic check_outputs();
    logic        e_req;
    logic [16:0] e_addr;
    logic        e_und;
    e_req  = fetching;
    e_addr = 17'(model_addr());
    e_und  = exp_underrun;
    vectors++;
    assert (mem_req === e_req) else begin
      miscompares++;
      $error("FAIL mem_req observed=%0b expected=%0b t=%0t", mem_req, e_req, $time);
    end
    if (fetching) begin
      assert (mem_addr === e_addr) else begin
        miscompares++;
        $error("FAIL mem_addr observed=%0d expected=%0d t=%0t", mem_addr, e_addr, $time);
      end
    end
    assert (underrun === e_und) else begin
      miscompares++;
      $error("FAIL underrun observed=%0b expected=%0b t=%0t", underrun, e_und, $time);
    end
    if (pix_known) begin
      assert (memMappedValue === exp_pix) else begin
        miscompares++;
        $error("FAIL pixel observed=%0d expected=%0d t=%0t", memMappedValue, exp_pix, $time);
      end
    end
  endtask

  // One clock: respond as memory, advance the model, then compare.
  task automatic step();
    int  x;
    int  y;
    int  t;
    int  b;
    bit  was;
    if (fetching) mem_data = memword(model_addr());
    else          mem_data = 20'($urandom);
    x = int'(DrawX);
    y = int'(DrawY);
    // playback reads the old bank contents of this cycle
    if (x >= 640 || y >= 480) begin
      exp_pix = 5'd0; pix_known = 1'b1;
    end else begin
      b = y % 2;
      if (refvalid[b][x / 4]) begin
        exp_pix   = 5'((refbank[b][x / 4] >> (5 * (x % 4))) & 20'h1F);
        pix_known = 1'b1;
      end else begin
        pix_known = 1'b0;
      end
    end
    was = fetching;
    if (line_start && was) exp_underrun = 1'b1;
    else if (clr_underrun) exp_underrun = 1'b0;
    if (line_start) begin
      t = (y == 524) ? 0 : y + 1;
      if (t < 480) begin
        fetching = 1'b1; m_t = t; m_base = int'(frame_base); m_idx = 0;
      end else begin
        fetching = 1'b0;
      end
    end else if (fetching && mem_ack) begin
      refbank[m_t % 2][m_idx]  = mem_data;
      refvalid[m_t % 2][m_idx] = 1'b1;
      m_idx++;
      if (m_idx == 160) fetching = 1'b0;
    end
    @(posedge Clk); #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse covering one clock edge.
  task automatic async_reset();
    Reset = 1'b0;
    #2;
    fetching = 1'b0; m_idx = 0; m_t = 0; m_base = 0;
    exp_underrun = 1'b0; exp_pix = 5'd0; pix_known = 1'b1;
    vectors++;
    assert (mem_req === 1'b0 && mem_addr === 17'd0) else begin
      miscompares++;
      $error("FAIL reset_req observed=%0b/%0d expected=0/0", mem_req, mem_addr);
    end
    assert (underrun === 1'b0 && memMappedValue === 5'd0) else begin
      miscompares++;
      $error("FAIL reset_flags observed=%0b/%0d expected=0/0", underrun, memMappedValue);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic run_line(input int y, input int base, input int mode,
                          input int reset_at, input int clr_at);
    for (int c = 0; c < 800; c++) begin
      DrawX        = 10'(c);
      DrawY        = 10'(y);
      frame_base   = 17'(base);
      line_start   = (c == 0);
      clr_underrun = (c == clr_at);
      case (mode)
        ACK_HIGH: mem_ack = 1'b1;
        ACK_LOW:  mem_ack = 1'b0;
        default:  mem_ack = ($urandom_range(0, 3) != 0);
      endcase
      if (c == reset_at) async_reset();
      else               step();
    end
  endtask

  initial begin
    Reset = 1'b0; line_start = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    frame_base = 17'd0; mem_ack = 1'b0; mem_data = 20'd0; clr_underrun = 1'b0;
    fetching = 1'b0; m_t = 0; m_base = 0; m_idx = 0;
    exp_underrun = 1'b0; exp_pix = 5'd0; pix_known = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_outputs();
    Reset = 1'b1;

    // line 10 fetched at base 0: addresses 1600..1759 back to back
    run_line(9, 0, ACK_HIGH, -1, -1);
    // display line 10 while fetching 11 with gappy acks
    run_line(10, 0, ACK_RAND, -1, -1);
    // reset while fetching line 12 at word 50
    run_line(11, 0, ACK_HIGH, 50, -1);
    // after reset the fetch of line 10 starts again from word 0
    run_line(9, 0, ACK_HIGH, -1, -1);
    // starved fetch, then underrun with a simultaneous clear
    run_line(10, 0, ACK_LOW, -1, -1);
    run_line(11, 0, ACK_RAND, -1, 0);
    run_line(12, 0, ACK_RAND, -1, 400);
    // line 0 fetched during line 524, then no fetch from line 479
    run_line(524, int'($urandom_range(0, 131071)), ACK_RAND, -1, -1);
    run_line(479, 0, ACK_HIGH, -1, -1);
    // blanked line with populated bank 0
    run_line(480, 0, ACK_HIGH, -1, -1);
    // address wrap at the top of the frame memory
    run_line(524, 131062, ACK_HIGH, -1, -1);
    run_line(0, 0, ACK_RAND, -1, -1);
    run_line(1, 0, ACK_RAND, -1, -1);
    // random lines, bases and ack patterns
    for (int i = 0; i < 6; i++) begin
      run_line(int'($urandom_range(0, 524)), int'($urandom_range(0, 131071)),
               int'($urandom_range(0, 2)), -1, int'($urandom_range(0, 1599)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_prefetch_buffer.md
# line_prefetch_buffer

Scanline prefetch stage that sits directly upstream of the 5-bit color mapper and drives its `memMappedValue` input. While line y is on screen, it fetches the palette indices for line y+1 from frame memory into a ping-pong line buffer. It then plays the current line back, one index per pixel clock, aligned to `DrawX`/`DrawY`.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_TOTAL`, 525: total lines per frame, blanking included.
- `WORDS_PER_LINE`, 160: memory words per line; each word holds 4 pixels.
- `ADDR_W`, 17: frame-memory word-address width.

Ports:
- `Clk`  in  1: pixel clock; the single clock of the block.
- `Reset`  in  1: asynchronous, active-low reset.
- `line_start`  in  1: one-cycle pulse in the first cycle of every line (`DrawX` = 0).
- `DrawX`  in  10: current pixel column.
- `DrawY`  in  10: current line.
- `frame_base`  in  `ADDR_W`: word address of line 0. Sampled at each `line_start`.
- `mem_req`  out  1: fetch request.
- `mem_addr`  out  `ADDR_W`: word address of the request.
- `mem_ack`  in  1: `mem_data` is valid this cycle for the current `mem_addr`.
- `mem_data`  in  20: four 5-bit indices. Bits [4:0] hold the leftmost pixel.
- `clr_underrun`  in  1: clears `underrun`.
- `memMappedValue`  out  5: palette index for the color mapper.
- `underrun`  out  1: sticky flag; a fetch did not complete before the next `line_start`.

## Operation
- Storage: two banks of `WORDS_PER_LINE` × 20 bits. Line t lives in bank t[0].
- Playback reads bank `DrawY[0]`. Word index = `DrawX[9:2]`; pixel within word = `DrawX[1:0]`.
- Target line at `line_start`:
  - t = 0 if `DrawY` = `V_TOTAL`−1, else t = `DrawY`+1.
  - A fetch starts only if t < `V_ACTIVE`; otherwise the FSM stays in IDLE.
  - Line 0 is therefore fetched during line 524, which is blanking, so the shared bank 0 never collides with a displayed line.
- Address = `frame_base` + t×160 + word_idx.
  - t×160 is computed as (t<<7)+(t<<5).
  - Sum is truncated to `ADDR_W` bits and wraps modulo 2^`ADDR_W`.
- FSM states:
  - IDLE: `mem_req`=0. On `line_start` with a valid target: latch t and `frame_base`, set word_idx=0, go to FETCH.
  - FETCH: `mem_req`=1, `mem_addr` = current address, held stable until `mem_ack`.
    - On `mem_ack`: write `mem_data` to bank t[0] at word_idx and increment word_idx.
    - If word_idx was `WORDS_PER_LINE`−1, go to DONE; otherwise present the next address in the following cycle with `mem_req` still high.
  - DONE: `mem_req`=0. Wait for `line_start`, then behave as IDLE.
- Simultaneous events:
  - `line_start` while in FETCH: set `underrun`, abandon the partial line, restart FETCH for the new target. An `mem_ack` in that same cycle is discarded.
  - `mem_ack` in a state other than FETCH is ignored.
- `underrun`:
  - Set has priority over `clr_underrun` in the same cycle.
  - Otherwise `clr_underrun` clears it.
- Blanking: `memMappedValue` = 0 whenever `DrawX` ≥ `H_ACTIVE` or `DrawY` ≥ `V_ACTIVE`.
- Banks are not cleared by reset. Visible lines whose fetch has not completed since reset show stale contents; this is allowed.

## Timing
- Reset values:
  - `memMappedValue` = 0, `mem_req` = 0, `mem_addr` = 0, `underrun` = 0.
  - FSM = IDLE; word_idx = 0.
- Reset is asynchronous. On assertion, `mem_req` drops immediately and the in-flight request is abandoned. The memory side must tolerate an abandoned request.
- Playback latency is exactly 1 cycle: `memMappedValue` in cycle k+1 corresponds to `DrawX`/`DrawY` sampled in cycle k. The downstream color mapper compensates by using a `DrawX` delayed by one cycle.
- Fetch throughput is at most 1 word per cycle (`mem_ack` held high). The minimum line fetch is 160 cycles after the FETCH entry cycle.
- The first `mem_req` is asserted in the cycle after `line_start`.
- Write/read hazard: none by construction, since fetch and playback use different banks. A same-bank access can occur only on line 524 → line 0, and line 524 is never displayed.

## Test plan
- Reset mid-FETCH, with `Reset` low for 1 cycle at word 50 → `mem_req` = 0 immediately, `underrun` = 0, FSM in IDLE. The next `line_start` with `DrawY` = 9 fetches line 10 starting from word 0.
- `frame_base` = 0, `mem_ack` tied high, `line_start` at `DrawY` = 9 → line 10 is fetched:
  - `mem_addr` runs 1600…1759 on consecutive cycles.
  - `mem_req` drops after word 1759.
  - On line 10, `DrawX` = 5 → the next cycle shows `mem_data`[9:5] of word 1601.
- `mem_ack` held low for 700 cycles, then the next `line_start` → `underrun` = 1, and the FETCH restarts at the new line's word 0.
  - `clr_underrun` asserted in the same cycle as a new underrun → `underrun` stays 1.
- `DrawY` = 524, `line_start` → target line 0, fetch addresses begin at `frame_base`.
  - `DrawY` = 479 → no fetch (`mem_req` stays 0).
- `frame_base` = 2^17 − 10, target line 0 → `mem_addr` wraps 131062…131071, 0, 1, …; no out-of-range value appears.
- `DrawX` = 640…799 or `DrawY` = 480 with nonzero buffer contents → `memMappedValue` = 0 one cycle later.
